// File: rtl/weight_fifo_sequencer_pkg.sv
// Shared definitions for the weight staging buffer.
//
// Contents:
//   - default parameter values: lane count, stage depth and word width;
//   - state_e, the sequencer state encoding, also exported on the debug port;
//   - lane_lsb / bus_width, helpers for slicing the packed lane buses.
package weight_fifo_sequencer_pkg;

  localparam int DEF_FIFO_INPUTS = 16;
  localparam int DEF_FIFO_DEPTH  = 16;
  localparam int DEF_DATA_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_STAGGER = 2'd2
  } state_e;

  // Bit offset of a lane inside a packed {lane N-1, ..., lane 0} bus.
  function automatic int lane_lsb(input int lane, input int data_width);
    return lane * data_width;
  endfunction

  // Total width of a packed bus carrying one word per lane.
  function automatic int bus_width(input int lanes, input int data_width);
    return lanes * data_width;
  endfunction

endpackage

// File: rtl/weight_lane_fifo.sv
// One lane of the weight staging buffer: a FIFO_DEPTH-stage shift register
// of DATA_WIDTH-bit words.
//
// Ports:
//   clk_i   rising-edge clock
//   rst_ni  asynchronous active-low reset, clears every stage
//   en_i    shift enable; with en_i=0 the lane holds all stages
//   d_i     word written into stage 0 on an enabled edge
//   q_o     final stage (registered), so the first word written appears
//           here after FIFO_DEPTH enabled edges
module weight_lane_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic [DATA_WIDTH-1:0] stage_q [FIFO_DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int k = 1; k < FIFO_DEPTH; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign q_o = stage_q[FIFO_DEPTH-1];

endmodule

// File: rtl/weight_fifo_sequencer.sv
// Weight staging buffer for the systolic array: FIFO_INPUTS independent
// byte-lane shift FIFOs plus the sequencer that drives their enables.
//
// A pass is requested by holding `active` high while idle. The mode is
// latched from `stagger_load` at pass start:
//   load    (0): every lane shifts for FIFO_DEPTH cycles;
//   stagger (1): lane i shifts during counter values i .. i+FIFO_DEPTH-1,
//                giving the diagonal wavefront that feeds the array skewed.
// `done` pulses on the last enabled cycle of a completed pass. Dropping
// `active` mid-pass returns to idle on the next edge with no done pulse and
// leaves the FIFO contents where they are.
//
// Handshake: `active` is a level request, not a valid/ready pair. It is
// sampled on every edge; in IDLE a 1 starts a pass (enables begin the
// following cycle), in LOAD/STAGGER a 0 aborts. Keeping it high across
// done starts the next pass after one IDLE cycle.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   active        pass request level
//   stagger_load  mode select, latched at pass start
//   weight_in     lane i = weight_in[i*DATA_WIDTH +: DATA_WIDTH]
//   weight_out    lane i = final stage of lane i
//   fifo_en       per-lane shift enables (Moore, from state and counter)
//   done          end-of-pass pulse (Moore)
//   dbg_state_o   current sequencer state
//   dbg_mode_o    mode latched for the current/last pass
module weight_fifo_sequencer
  import weight_fifo_sequencer_pkg::*;
#(
  parameter int FIFO_INPUTS = DEF_FIFO_INPUTS,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           active,
  input  logic                                           stagger_load,
  input  logic [bus_width(FIFO_INPUTS, DATA_WIDTH)-1:0]  weight_in,
  output logic [bus_width(FIFO_INPUTS, DATA_WIDTH)-1:0]  weight_out,
  output logic [FIFO_INPUTS-1:0]                         fifo_en,
  output logic                                           done,
  output state_e                                         dbg_state_o,
  output logic                                           dbg_mode_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + FIFO_INPUTS);

  // Last counter value of each pass type. A stagger pass runs until the
  // highest lane has had its FIFO_DEPTH enabled cycles.
  localparam logic [CNT_W-1:0] LOAD_LAST    = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(FIFO_DEPTH + FIFO_INPUTS - 2);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;

  // ---------------------------------------------------------------------
  // Sequencer state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;

    case (state_q)
      ST_IDLE: begin
        if (active) begin
          mode_d  = stagger_load;
          cnt_d   = '0;
          state_d = stagger_load ? ST_STAGGER : ST_LOAD;
        end
      end

      ST_LOAD: begin
        // Abort takes priority; the counter is simply left behind since it
        // is cleared again at the next pass start.
        if (!active || (cnt_q == LOAD_LAST)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_STAGGER: begin
        if (!active || (cnt_q == STAGGER_LAST)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Moore outputs: enables and done depend only on state and counter, so
  // an abort still shows the enables of the cycle in which active fell
  // (that edge performs one more shift before returning to idle).
  // ---------------------------------------------------------------------
  always_comb begin
    fifo_en = '0;
    done    = 1'b0;

    case (state_q)
      ST_LOAD: begin
        fifo_en = '1;
        done    = (cnt_q == LOAD_LAST);
      end

      ST_STAGGER: begin
        // Lane i's window is counter values [i, i+FIFO_DEPTH).
        for (int i = 0; i < FIFO_INPUTS; i++) begin
          fifo_en[i] = (int'(cnt_q) >= i) && (int'(cnt_q) < i + FIFO_DEPTH);
        end
        done = (cnt_q == STAGGER_LAST);
      end

      default: begin
        fifo_en = '0;
        done    = 1'b0;
      end
    endcase
  end

  assign dbg_state_o = state_q;
  assign dbg_mode_o  = mode_q;

  // ---------------------------------------------------------------------
  // Lane FIFOs: lanes never interact, each sees only its own enable.
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < FIFO_INPUTS; g++) begin : g_lane
    weight_lane_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_lane (
      .clk_i  (clk),
      .rst_ni (reset),
      .en_i   (fifo_en[g]),
      .d_i    (weight_in[lane_lsb(g, DATA_WIDTH) +: DATA_WIDTH]),
      .q_o    (weight_out[lane_lsb(g, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_weight_fifo_sequencer.sv
// Directed bench for weight_fifo_sequencer at default parameters
// (16 lanes, 16 stages, 8-bit words).
module tb_weight_fifo_sequencer;
  import weight_fifo_sequencer_pkg::*;

  localparam int N  = 16;
  localparam int D  = 16;
  localparam int W  = 8;
  localparam int BW = N * W;

  // -------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          reset;
  logic          active;
  logic          stagger_load;
  logic [BW-1:0] weight_in;
  logic [BW-1:0] weight_out;
  logic [N-1:0]  fifo_en;
  logic          done;
  state_e        dbg_state;
  logic          dbg_mode;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  weight_fifo_sequencer #(
    .FIFO_INPUTS (N),
    .FIFO_DEPTH  (D),
    .DATA_WIDTH  (W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .active       (active),
    .stagger_load (stagger_load),
    .weight_in    (weight_in),
    .weight_out   (weight_out),
    .fifo_en      (fifo_en),
    .done         (done),
    .dbg_state_o  (dbg_state),
    .dbg_mode_o   (dbg_mode)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------------
  // Driver / checker helpers
  // -------------------------------------------------------------------
  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int idx,
                     input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] rep(input logic [W-1:0] b);
    return {N{b}};
  endfunction

  // Expected stagger enables: growing mask of ones up to c=15, then ones
  // shifted out from the bottom.
  function automatic logic [N-1:0] stag_en(input int c);
    logic [31:0] t;
    if (c < D) t = (32'h1 << (c + 1)) - 32'h1;
    else       t = 32'h0000_FFFF << (c - (D - 1));
    return t[N-1:0];
  endfunction

  // Expected output during a stagger drain of a FIFO whose stage j holds
  // 16-j (word j = j+1 at the output), with zeros shifted in. Lane i has
  // had clamp(c-i, 0, 16) shifts when the counter reads c.
  function automatic logic [BW-1:0] stag_out(input int c);
    logic [BW-1:0] o;
    int s;
    o = '0;
    for (int i = 0; i < N; i++) begin
      s = c - i;
      if (s < 0) s = 0;
      if (s > D) s = D;
      o[i*W +: W] = (s == D) ? '0 : W'(s + 1);
    end
    return o;
  endfunction

  // -------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------
  logic [BW-1:0] desc_data;
  logic [W-1:0]  v;

  initial begin
    for (int i = 0; i < N; i++) desc_data[i*W +: W] = W'(16 - i);

    // 1. Reset held with active=1.
    reset        = 1'b0;
    active       = 1'b1;
    stagger_load = 1'b0;
    weight_in    = '0;
    repeat (3) tick();
    chk("rst_en",    0, BW'(fifo_en), '0);
    chk("rst_done",  0, BW'(done), '0);
    chk("rst_out",   0, weight_out, '0);
    chk("rst_state", 0, BW'(dbg_state), BW'(ST_IDLE));

    // Release away from the edge; nothing enabled until active is sampled.
    weight_in = desc_data;
    reset     = 1'b1;
    #2;
    chk("rel_en", 0, BW'(fifo_en), '0);

    // 2. Load pass with lane i = 16-i.
    tick();
    for (int k = 0; k < D; k++) begin
      chk("load_en",   k, BW'(fifo_en), BW'(16'hFFFF));
      chk("load_done", k, BW'(done), BW'(k == D - 1));
      if (k == D - 1) active = 1'b0;
      tick();
    end
    chk("load_idle_en", 0, BW'(fifo_en), '0);
    chk("load_out",     0, weight_out, desc_data);
    repeat (3) tick();
    chk("load_hold_out",  0, weight_out, desc_data);
    chk("load_hold_done", 0, BW'(done), '0);

    // 3. Load distinct per-cycle data (cycle k writes k+1 everywhere).
    active = 1'b1;
    stagger_load = 1'b0;
    tick();
    for (int k = 0; k < D; k++) begin
      chk("dl_en", k, BW'(fifo_en), BW'(16'hFFFF));
      weight_in = rep(W'(k + 1));
      if (k == D - 1) active = 1'b0;
      tick();
    end
    chk("dl_out", 0, weight_out, rep(8'd1));

    // 3/4. Stagger drain with zeros in; check enables, done and skew.
    weight_in    = '0;
    active       = 1'b1;
    stagger_load = 1'b1;
    tick();
    for (int c = 0; c <= D + N - 2; c++) begin
      chk("stg_en",   c, BW'(fifo_en), BW'(stag_en(c)));
      chk("stg_done", c, BW'(done), BW'(c == D + N - 2));
      chk("stg_out",  c, weight_out, stag_out(c));
      if (c == D + N - 2) active = 1'b0;
      tick();
    end
    chk("stg_end_out",   0, weight_out, '0);
    chk("stg_end_en",    0, BW'(fifo_en), '0);
    chk("stg_end_state", 0, BW'(dbg_state), BW'(ST_IDLE));

    // 5. Abort a load at c=5 after writing A0..A5.
    active = 1'b1;
    stagger_load = 1'b0;
    tick();
    for (int k = 0; k <= 5; k++) begin
      chk("ab_en",   k, BW'(fifo_en), BW'(16'hFFFF));
      chk("ab_done", k, BW'(done), '0);
      weight_in = rep(8'hA0 + W'(k));
      if (k == 5) active = 1'b0;
      tick();
    end
    chk("ab_after_en", 0, BW'(fifo_en), '0);
    for (int k = 0; k < 2; k++) begin
      chk("ab_after_done", k, BW'(done), '0);
      tick();
    end

    // Drain with zeros: the six held words surface at c=10..15.
    weight_in = '0;
    active    = 1'b1;
    tick();
    for (int c = 0; c < D; c++) begin
      v = (c >= 10) ? (8'hA0 + W'(c - 10)) : 8'h00;
      chk("ab_drain_out",  c, weight_out, rep(v));
      chk("ab_drain_done", c, BW'(done), BW'(c == D - 1));
      if (c == D - 1) active = 1'b0;
      tick();
    end

    // 6. Back-to-back: load, then stagger, then load, with active held.
    active = 1'b1;
    stagger_load = 1'b0;
    tick();
    for (int k = 0; k < D; k++) begin
      chk("b2b_load_en",   k, BW'(fifo_en), BW'(16'hFFFF));
      chk("b2b_load_done", k, BW'(done), BW'(k == D - 1));
      if (k == D - 1) stagger_load = 1'b1;
      tick();
    end
    chk("b2b_gap_en",   0, BW'(fifo_en), '0);
    chk("b2b_gap_done", 0, BW'(done), '0);
    tick();
    chk("b2b_mode", 0, BW'(dbg_mode), BW'(1'b1));
    for (int c = 0; c <= D + N - 2; c++) begin
      chk("b2b_stg_en",   c, BW'(fifo_en), BW'(stag_en(c)));
      chk("b2b_stg_done", c, BW'(done), BW'(c == D + N - 2));
      if (c == D + N - 2) stagger_load = 1'b0;
      tick();
    end
    chk("b2b_gap2_en", 0, BW'(fifo_en), '0);
    tick();
    chk("b2b_load2_en", 0, BW'(fifo_en), BW'(16'hFFFF));
    chk("b2b_load2_mode", 0, BW'(dbg_mode), '0);
    active = 1'b0;
    tick();
    chk("b2b_abort_en",   0, BW'(fifo_en), '0);
    chk("b2b_abort_done", 0, BW'(done), '0);
    repeat (2) tick();

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/weight_fifo_sequencer.md
Name: weight_fifo_sequencer

Overview:
Weight staging buffer for the systolic array. It holds FIFO_INPUTS parallel byte-lane shift FIFOs, each FIFO_DEPTH deep, plus a sequencer that drives their per-lane enables.
- Load mode: all lanes shift together for FIFO_DEPTH cycles.
- Stagger mode: lanes drain in a diagonal wavefront, so lane i starts shifting i cycles after lane 0. This feeds the array skewed.
- A one-cycle done pulse marks the end of each pass.

Parameters:
FIFO_INPUTS, 16, number of lanes (columns).
FIFO_DEPTH, 16, stages per lane; also the enable length per lane per pass.
DATA_WIDTH, 8, bits per lane word.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset; one clock domain only.
active  input  1  level request to run a pass; sampled in IDLE.
stagger_load  input  1  mode select latched at pass start: 0 = load, 1 = stagger drain.
weight_in  input  FIFO_INPUTS*DATA_WIDTH  lane i = weight_in[i*DATA_WIDTH +: DATA_WIDTH].
weight_out  output  FIFO_INPUTS*DATA_WIDTH  lane i = final stage of lane i FIFO.
fifo_en  output  FIFO_INPUTS  current per-lane shift enables, exported for observation.
done  output  1  one-cycle pulse on the last enabled cycle of a pass.

Behaviour:
- Reset (reset=0, async): state IDLE, counter 0, mode 0, all FIFO stages 0. Outputs: fifo_en=0, done=0, weight_out=0.
- States: IDLE, LOAD, STAGGER.
- IDLE: if active=1 at a clock edge:
  - latch mode from stagger_load;
  - clear the counter;
  - go to LOAD (mode 0) or STAGGER (mode 1).
  - The first enable cycle is therefore the cycle after active is sampled.
- fifo_en and done are combinational from state and counter (Moore); there are no glitch-sensitive consumers.
- LOAD, counter c = 0..FIFO_DEPTH-1:
  - fifo_en = all ones;
  - done = 1 when c = FIFO_DEPTH-1, then return to IDLE.
- STAGGER, counter c = 0..FIFO_DEPTH+FIFO_INPUTS-2:
  - fifo_en[i] = (c >= i) and (c < i+FIFO_DEPTH);
  - done = 1 when c = FIFO_DEPTH+FIFO_INPUTS-2 (31 cycles total at defaults), then return to IDLE.
- active is a level request:
  - if still 1 in IDLE after done, a new pass starts, using the stagger_load value at that time;
  - active=0 during LOAD or STAGGER aborts to IDLE the next edge with no done pulse;
  - FIFO contents are kept on abort.
- Lane FIFO (per lane i): on a clock edge with fifo_en[i]=1:
  - stage0 <= weight_in lane i;
  - stage k <= stage k-1 for each k.
  - With fifo_en[i]=0 the lane holds.
  - weight_out lane i = stage FIFO_DEPTH-1, a register output; the first word written reaches it after FIFO_DEPTH enabled edges.
- Width: counter is clog2(FIFO_DEPTH+FIFO_INPUTS) bits; no arithmetic on data.
- Lanes never interact; enables outside the window leave that lane frozen.

Decomposition:
- Package: state enum (IDLE/LOAD/STAGGER), default parameter constants, and the lane-slice width helper.
- One natural sub-module, weight_lane_fifo: a single DATA_WIDTH x FIFO_DEPTH shift FIFO with en, generated FIFO_INPUTS times.
- The sequencer FSM stays in the top level.

Test Plan:
1. Reset: hold reset=0 with active=1 -> fifo_en=0, done=0, weight_out=0. Release -> first fifo_en nonzero exactly 1 cycle after active is sampled.
2. Load mode: active=1, stagger_load=0, weight_in lane i = 16-i (lane 15 = 1, lane 0 = 16) for 16 cycles. Required:
   - fifo_en = 16'hFFFF for 16 cycles;
   - done high only on the 16th;
   - afterwards weight_out lane i = 16-i, held while idle (active=0).
3. Stagger drain: after a load with per-cycle distinct data (cycle k writes k+1 to all lanes), set weight_in=0, active=1, stagger_load=1. Required:
   - fifo_en = 0x0001, 0x0003, …, 0xFFFF (c=15), 0xFFFE, …, 0x8000 (c=30);
   - done at c=30;
   - at the end all lanes output 0.
4. Stagger skew: in scenario 3, lane 0 output changes 1 cycle after enable starts and lane 15 changes 15 cycles later. Lane i presents loaded word j at relative cycle i+j.
5. Abort: drop active at LOAD c=5 -> fifo_en=0 the next cycle, no done pulse, lanes hold their 6-shift contents.
6. Back-to-back: keep active=1 across done with stagger_load toggled -> the next pass starts the cycle after done in the new mode.
